// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the serial boot loader: FSM state encoding,
// frame constants and header field widths.
package uart_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR0,
        S_ADDR1,
        S_CNT0,
        S_CNT1,
        S_DATA,
        S_WRITE,
        S_RESP0,
        S_RESP1,
        S_DONE
    } state_t;

    localparam logic [23:0] TIMEOUT_DEFAULT = 24'd1000000;
    localparam logic [7:0]  SYNC_DEFAULT    = 8'hA5;
    localparam logic [7:0]  ACK_DEFAULT     = 8'h06;
    localparam int          BASE_W          = 16;
    localparam int          COUNT_W         = 16;
    localparam int          BUS_ADDR_W      = 30;

    // States in which an empty rx FIFO counts towards the inter-byte timeout.
    function automatic logic is_timed(input state_t s);
        return (s == S_ADDR0) || (s == S_ADDR1) || (s == S_CNT0) ||
               (s == S_CNT1)  || (s == S_DATA);
    endfunction

endpackage

// File: rtl/uart_loader_timeout.sv
// Inter-byte timeout: loadable down-counter, reloaded on clear, decremented
// while enabled; a zero TIMEOUT disables expiry entirely.
module uart_loader_timeout #(
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [23:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= TIMEOUT;
        end else if (enable && cnt_q != 24'd0) begin
            cnt_q <= cnt_q - 24'd1;
        end
    end

    assign expired = (TIMEOUT != 24'd0) && (cnt_q == 24'd0);

endmodule

// File: rtl/uart_loader.sv
// Serial boot loader: parses SYNC/base/count/payload frames from the UART rx
// FIFO, writes words to RAM over the shared bus, then answers ACK + checksum.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT,
    parameter logic [7:0]  SYNC    = SYNC_DEFAULT,
    parameter logic [7:0]  ACK     = ACK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_empty,
    output logic                  rd_rx,
    output logic [7:0]            tx_data,
    input  logic                  tx_full,
    output logic                  wr_tx,
    output logic                  bus_req,
    output logic [BUS_ADDR_W-1:0] addr,
    output logic [31:0]           wdata,
    output logic [3:0]            we,
    output logic                  cpu_reset
);

    state_t               state_q, state_d;
    logic [BASE_W-1:0]    waddr_q;
    logic [COUNT_W-1:0]   remain_q;
    logic [1:0]           idx_q;
    logic [23:0]          asm_q;
    logic [31:0]          wdata_q;
    logic [BUS_ADDR_W-1:0] addr_q;
    logic [7:0]           sum_q;

    logic timed;
    logic expired;
    logic pop;
    logic pop_state;

    assign timed     = is_timed(state_q);
    assign pop_state = (state_q == S_IDLE) || timed;
    // An expiring cycle never pops, so no byte is lost on the way back to IDLE.
    assign pop       = !reset && pop_state && !rx_empty && !(timed && expired);

    uart_loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!timed || pop),
        .enable  (timed && rx_empty),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // infer a latch. Reset also gates the outputs so a mid-frame reset takes
    // effect in the very cycle it is asserted.
    always_comb begin
        state_d   = state_q;
        rd_rx     = pop;
        wr_tx     = 1'b0;
        tx_data   = sum_q;
        we        = 4'h0;
        bus_req   = 1'b0;
        cpu_reset = 1'b0;
        addr      = reset ? '0 : addr_q;
        wdata     = reset ? '0 : wdata_q;

        case (state_q)
            S_IDLE:  if (pop && rx_data == SYNC) state_d = S_ADDR0;
            S_ADDR0: if (pop) state_d = S_ADDR1;
            S_ADDR1: if (pop) state_d = S_CNT0;
            S_CNT0:  if (pop) state_d = S_CNT1;
            S_CNT1:  if (pop) state_d = ({rx_data, remain_q[7:0]} == '0) ? S_RESP0 : S_DATA;
            S_DATA:  if (pop && idx_q == 2'd3) state_d = S_WRITE;
            S_WRITE: state_d = (remain_q == 16'd1) ? S_RESP0 : S_DATA;
            S_RESP0: begin
                tx_data = ACK;
                if (!tx_full) state_d = S_RESP1;
            end
            S_RESP1: if (!tx_full) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (timed && expired) state_d = S_IDLE;

        if (!reset) begin
            wr_tx     = (state_q == S_RESP0 || state_q == S_RESP1) && !tx_full;
            we        = (state_q == S_WRITE) ? 4'hF : 4'h0;
            bus_req   = (state_q == S_DATA) || (state_q == S_WRITE);
            cpu_reset = (state_q != S_IDLE);
        end
    end

    // Header fields, byte assembly and checksum; wdata/addr only change on the
    // edge into WRITE so they stay stable outside the write cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            waddr_q  <= '0;
            remain_q <= '0;
            idx_q    <= '0;
            asm_q    <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            sum_q    <= '0;
        end else if (pop) begin
            case (state_q)
                S_IDLE:  if (rx_data == SYNC) sum_q <= '0;
                S_ADDR0: waddr_q[7:0]   <= rx_data;
                S_ADDR1: waddr_q[15:8]  <= rx_data;
                S_CNT0:  remain_q[7:0]  <= rx_data;
                S_CNT1: begin
                    remain_q[15:8] <= rx_data;
                    idx_q          <= '0;
                    sum_q          <= '0;
                end
                S_DATA: begin
                    sum_q <= sum_q + rx_data;
                    idx_q <= idx_q + 2'd1;
                    asm_q <= {rx_data, asm_q[23:8]};
                    if (idx_q == 2'd3) begin
                        wdata_q <= {rx_data, asm_q};
                        addr_q  <= {{(BUS_ADDR_W-BASE_W){1'b0}}, waddr_q};
                    end
                end
                default: ;
            endcase
        end else if (state_q == S_WRITE) begin
            waddr_q  <= waddr_q + 16'd1;
            remain_q <= remain_q - 16'd1;
        end
    end

endmodule
